stream_demux_1to6_32b: RTL and testbench
========================================

Name: stream_demux_1to6_32b

Overview:
- Registered 1-to-6 stream demultiplexer for the CGRA interconnect; the transmit-side counterpart of the 6-input select mux.
- Steers one valid/ready input stream to one of six output ports, to all six (broadcast), or to a discard sink, as chosen by a 3-bit select.
- Each output has a one-entry register slot, so there is no combinational data path from input to output and every port has independent backpressure.

Parameters:
- size, 32, data width per port.
- CNT_W, 8, width of the saturating discard counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  size  input word.
- in_valid  input  1  input word present.
- in_ready  output  1  input word accepted this cycle when in_valid=1.
- select  input  3  0-5 selects a port; 6 broadcasts; 7 discards. Sampled only on a transfer.
- out_data  output  6*size  port i occupies bits [i*size +: size].
- out_valid  output  6  per-port slot occupied.
- out_ready  input  6  per-port sink ready.
- drop_count  output  CNT_W  number of discarded words, saturating.

Behaviour:
- Reset (rst high at a clk edge):
  - all slots become invalid: out_valid=6'b0.
  - out_data=0.
  - drop_count=0.
  - in_ready follows the combinational rule below, so it evaluates to 1 once all slots are empty.
  - Any word partially in flight is lost; no transfer is counted in a reset cycle.
- Slot state: slot_valid[i] and slot_data[i]. out_valid[i]=slot_valid[i]; out_data slice i = slot_data[i]. Both are driven directly from registers.
- Output handshake: an output transfer on port i happens when out_valid[i] & out_ready[i]. Once asserted, out_valid[i] and its data stay stable until that transfer.
- free[i] = ~slot_valid[i] | out_ready[i].
- in_ready is combinational from select, slot_valid and out_ready:
  - select 0-5: in_ready = free[select].
  - select 6: in_ready = &free (all six ports).
  - select 7: in_ready = 1.
- Input transfer = in_valid & in_ready. in_valid is never used to generate in_ready.
- Per-slot update at each clk edge (not in reset):
  - If slot i is loaded (transfer with select==i, or select==6): slot_data[i] <= in_data; slot_valid[i] <= 1.
  - Else if out_ready[i] & slot_valid[i]: slot_valid[i] <= 0; slot_data[i] holds.
  - Else: hold.
- Simultaneous drain and load on the same slot: the new word replaces the old one and valid stays 1. This gives 1 word/cycle per port.
- Latency: a word accepted at edge N is visible on its port(s) after edge N, i.e. one cycle.
- Broadcast: all-or-nothing. The word is accepted only when all six ports are free, then loaded into all six slots on the same edge. The six ports then drain independently.
- Discard (select 7): the word is accepted unconditionally, no slot changes, and drop_count increments by 1. At 2^CNT_W-1 the counter holds (saturates, never wraps).
- Select changes while in_valid=1 and in_ready=0 are legal. in_ready re-evaluates against the new select, and no state changes until a transfer.
- Ports not targeted by a transfer continue draining normally in the same cycle.
- No x outputs: all values are defined after reset.

Test Plan:
- Reset, then hold out_ready=0. Send 0xA5A5_0001 with select=2 → in_ready=1 and the word is accepted. Next cycle out_valid=6'b000100 and slice 2 = 0xA5A5_0001. A second word to port 2 sees in_ready=0 until out_ready[2]=1.
- Streaming: out_ready=6'h3F, select=4, send words 1..8 back-to-back → in_ready stays 1. Port 4 emits 1..8 on consecutive cycles, one cycle behind the input.
- Broadcast: slot 3 pre-filled and out_ready[3]=0; send 0xDEAD_BEEF with select=6 → in_ready=0. When out_ready[3]=1, in_ready=1 that cycle. Next cycle out_valid=6'h3F and every slice = 0xDEAD_BEEF.
- Discard/saturation: with CNT_W=8, send 300 words with select=7 and out_ready=0 → in_ready is always 1, out_valid stays 0, drop_count=255.
- Mid-operation reset: fill slots 0 and 5 and set drop_count=3, then assert rst for one cycle → out_valid=0, out_data=0, drop_count=0. The first post-reset word to port 0 appears normally.
- Select switch while stalled: port 1 full, in_valid=1, select=1 (stalled); change select to 0 → accepted that cycle into port 0, and port 1's contents are unchanged.

Source files
------------

// File: rtl/stream_demux_1to6_32b.sv
// Registered 1-to-6 stream demultiplexer with broadcast and discard modes.
// Each output owns a one-entry slot, so no combinational path runs from input to output.
module stream_demux_1to6_32b #(
  parameter int size  = 32,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [size-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        select,
  output logic [6*size-1:0] out_data,
  output logic [5:0]        out_valid,
  input  logic [5:0]        out_ready,
  output logic [CNT_W-1:0]  drop_count
);

  logic [5:0]       slot_valid_r;
  logic [size-1:0]  slot_data_r [6];
  logic [CNT_W-1:0] drop_count_r;

  logic [5:0]       free_s;
  logic             in_ready_s;
  logic             xfer_s;
  logic [5:0]       load_s;
  logic             drop_s;

  // A slot can take a word if it is empty or its current word leaves this cycle.
  always_comb begin
    free_s = ~slot_valid_r | out_ready;
  end

  // Acceptance depends only on the selected target(s); in_valid never feeds back.
  always_comb begin
    in_ready_s = 1'b0;
    case (select)
      3'd0:    in_ready_s = free_s[0];
      3'd1:    in_ready_s = free_s[1];
      3'd2:    in_ready_s = free_s[2];
      3'd3:    in_ready_s = free_s[3];
      3'd4:    in_ready_s = free_s[4];
      3'd5:    in_ready_s = free_s[5];
      3'd6:    in_ready_s = &free_s;
      3'd7:    in_ready_s = 1'b1;
      default: in_ready_s = 1'b0;
    endcase
  end

  // Decode the accepted word into per-slot loads or a discard.
  always_comb begin
    xfer_s = in_valid & in_ready_s;
    drop_s = xfer_s & (select == 3'd7);
    load_s = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      if (xfer_s && ((select == 3'(i)) || (select == 3'd6))) begin
        load_s[i] = 1'b1;
      end else begin
        load_s[i] = 1'b0;
      end
    end
  end

  // Slot registers: a load wins over a drain so a port sustains one word per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_r <= 6'b000000;
      for (int i = 0; i < 6; i++) begin
        slot_data_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (load_s[i]) begin
          slot_valid_r[i] <= 1'b1;
          slot_data_r[i]  <= in_data;
        end else if (out_ready[i] && slot_valid_r[i]) begin
          slot_valid_r[i] <= 1'b0;
        end
      end
    end
  end

  // Saturating count of discarded words.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count_r <= '0;
    end else if (drop_s && (drop_count_r != {CNT_W{1'b1}})) begin
      drop_count_r <= drop_count_r + CNT_W'(1);
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = slot_valid_r;
  assign drop_count = drop_count_r;

  for (genvar g = 0; g < 6; g++) begin : g_out
    assign out_data[g*size +: size] = slot_data_r[g];
  end

endmodule

// File: tb/tb_stream_demux_1to6_32b.sv
// Directed bench for stream_demux_1to6_32b: queue-based reference model checked every cycle,
// plus hand-computed expectations at the key points of each scenario.
module tb_stream_demux_1to6_32b;

  logic         clk;
  logic         rst;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   select;
  logic [191:0] out_data;
  logic [5:0]   out_valid;
  logic [5:0]   out_ready;
  logic [7:0]   drop_count;

  int checks;
  int failures;

  stream_demux_1to6_32b #(.size(32), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .select     (select),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each port is a FIFO of capacity one; last-shown word persists after draining.
  logic [31:0] mq [6][$];
  logic [31:0] mlast [6];
  int          mdrop;
  bit          mstarted;

  function automatic bit model_ready(input logic [2:0] sel, input logic [5:0] ordy);
    bit all_free;
    all_free = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (mq[i].size() != 0 && !ordy[i]) all_free = 1'b0;
    end
    if (sel == 3'd7) return 1'b1;
    if (sel == 3'd6) return all_free;
    return (mq[sel].size() == 0) || ordy[sel];
  endfunction

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    mdrop    = 0;
    mstarted = 1'b0;
    for (int i = 0; i < 6; i++) mlast[i] = 32'h0;
  end

  always @(posedge clk) begin
    bit acc;
    if (rst) begin
      for (int i = 0; i < 6; i++) begin
        mq[i].delete();
        mlast[i] = 32'h0;
      end
      mdrop    = 0;
      mstarted = 1'b1;
    end else if (mstarted) begin
      acc = in_valid && model_ready(select, out_ready);
      for (int i = 0; i < 6; i++) begin
        if (mq[i].size() != 0 && out_ready[i]) void'(mq[i].pop_front());
      end
      if (acc) begin
        if (select == 3'd7) begin
          if (mdrop < 255) mdrop = mdrop + 1;
        end else begin
          for (int i = 0; i < 6; i++) begin
            if (select == 3'd6 || int'(select) == i) begin
              mq[i].push_back(in_data);
              mlast[i] = in_data;
            end
          end
        end
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    logic [5:0]   ev;
    logic [191:0] ed;
    if (mstarted) begin
      for (int i = 0; i < 6; i++) begin
        ev[i] = (mq[i].size() != 0);
        ed[i*32 +: 32] = mlast[i];
      end
      chk("model_out_valid", {186'd0, out_valid}, {186'd0, ev});
      chk("model_out_data", out_data, ed);
      chk("model_drop_count", {184'd0, drop_count}, 192'(mdrop));
      chk("model_in_ready", {191'd0, in_ready}, {191'd0, model_ready(select, out_ready)});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  logic [31:0] port1_old;

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_data   = 32'h0;
    in_valid  = 1'b0;
    select    = 3'd0;
    out_ready = 6'h00;
    cyc();
    cyc();
    chk("reset_out_valid", {186'd0, out_valid}, 192'd0);
    chk("reset_out_data", out_data, 192'd0);
    chk("reset_drop_count", {184'd0, drop_count}, 192'd0);
    chk("reset_in_ready", {191'd0, in_ready}, 192'd1);
    rst = 1'b0;
    cyc();

    // Single word to port 2, then backpressure on a second word.
    select = 3'd2; in_data = 32'hA5A5_0001; in_valid = 1'b1;
    #1 chk("p2_first_ready", {191'd0, in_ready}, 192'd1);
    cyc();
    in_data = 32'hA5A5_0002;
    chk("p2_out_valid", {186'd0, out_valid}, 192'h04);
    chk("p2_slice", {160'd0, out_data[2*32 +: 32]}, 192'hA5A5_0001);
    #1 chk("p2_second_stall", {191'd0, in_ready}, 192'd0);
    cyc();
    chk("p2_hold", {160'd0, out_data[2*32 +: 32]}, 192'hA5A5_0001);
    out_ready = 6'b000100;
    #1 chk("p2_ready_on_drain", {191'd0, in_ready}, 192'd1);
    cyc();
    in_valid = 1'b0;
    chk("p2_replaced", {160'd0, out_data[2*32 +: 32]}, 192'hA5A5_0002);
    chk("p2_valid_kept", {186'd0, out_valid}, 192'h04);

    // Streaming 1..8 to port 4.
    out_ready = 6'h3F; select = 3'd4;
    for (int w = 1; w <= 8; w++) begin
      in_data = 32'(w); in_valid = 1'b1;
      #1 chk("stream_ready", {191'd0, in_ready}, 192'd1);
      cyc();
      chk("stream_slice4", {160'd0, out_data[4*32 +: 32]}, 192'(w));
    end
    in_valid = 1'b0;
    cyc();
    cyc();

    // Broadcast blocked by a stalled port 3.
    out_ready = 6'h00; select = 3'd3; in_data = 32'h0000_0033; in_valid = 1'b1;
    cyc();
    select = 3'd6; in_data = 32'hDEAD_BEEF;
    #1 chk("bcast_stall", {191'd0, in_ready}, 192'd0);
    cyc();
    chk("bcast_no_load", {186'd0, out_valid}, 192'h08);
    out_ready = 6'b001000;
    #1 chk("bcast_ready", {191'd0, in_ready}, 192'd1);
    cyc();
    in_valid = 1'b0;
    chk("bcast_valid", {186'd0, out_valid}, 192'h3F);
    chk("bcast_data", out_data, {6{32'hDEAD_BEEF}});
    out_ready = 6'h3F;
    cyc();
    chk("bcast_drained", {186'd0, out_valid}, 192'h00);

    // Discard saturation.
    out_ready = 6'h00; select = 3'd7; in_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      in_data = 32'(n);
      #1 if (!in_ready) chk("discard_ready", {191'd0, in_ready}, 192'd1);
      cyc();
    end
    in_valid = 1'b0;
    chk("discard_count", {184'd0, drop_count}, 192'd255);
    chk("discard_no_valid", {186'd0, out_valid}, 192'd0);

    // Mid-operation reset.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    select = 3'd7; in_valid = 1'b1;
    cyc(); cyc(); cyc();
    chk("pre_reset_count", {184'd0, drop_count}, 192'd3);
    select = 3'd0; in_data = 32'h1111_0000;
    cyc();
    select = 3'd5; in_data = 32'h5555_0005;
    cyc();
    in_valid = 1'b0;
    chk("pre_reset_valid", {186'd0, out_valid}, 192'h21);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_reset_valid", {186'd0, out_valid}, 192'd0);
    chk("mid_reset_data", out_data, 192'd0);
    chk("mid_reset_count", {184'd0, drop_count}, 192'd0);
    select = 3'd0; in_data = 32'h0BAD_F00D; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("post_reset_p0", {160'd0, out_data[31:0]}, 192'h0BAD_F00D);
    chk("post_reset_valid", {186'd0, out_valid}, 192'h01);

    // Select switch while stalled on a full port 1.
    select = 3'd1; in_data = 32'h1010_1010; in_valid = 1'b1;
    cyc();
    port1_old = 32'h1010_1010;
    out_ready = 6'b000001;
    in_data = 32'h2020_2020;
    #1 chk("switch_stall", {191'd0, in_ready}, 192'd0);
    cyc();
    select = 3'd0;
    #1 chk("switch_ready", {191'd0, in_ready}, 192'd1);
    cyc();
    in_valid = 1'b0;
    chk("switch_p0", {160'd0, out_data[31:0]}, 192'h2020_2020);
    chk("switch_p1_kept", {160'd0, out_data[1*32 +: 32]}, {160'd0, port1_old});
    chk("switch_valid", {186'd0, out_valid}, 192'h03);

    out_ready = 6'h3F;
    cyc();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
